counter_report_tx: RTL and testbench
====================================

Name: counter_report_tx

Overview:
Transmit-side companion to the counter command decoder. Where the decoder turns received UART bytes into run/clear/mode controls, this block turns counter state into ASCII bytes for the UART TX FIFO. On a report request it snapshots the 0..9999 counter value and the up/down mode, converts the value to BCD sequentially, and pushes a fixed 8-byte frame into the TX FIFO under a push/full handshake. It sits between the counter datapath/controller and the TX FIFO write port inside counter_top.

Parameters:
CNT_W, 14, width of the counter value input
MAX_CNT, 9999, saturation limit applied before conversion
EOL_EN, 1, 1 appends CR LF to the frame (8 bytes); 0 omits them (6 bytes)

Ports:
clk  input  1  system clock
rst  input  1  asynchronous reset, active-low
count  input  CNT_W  live counter value
mode  input  1  0 = up, 1 = down
report_req  input  1  single-cycle request to send a report
fifo_full  input  1  TX FIFO full flag (registered in the FIFO)
push  output  1  TX FIFO write strobe
wdata  output  8  byte to write; valid when push=1
busy  output  1  high from request acceptance until the last byte is pushed

Behaviour:
- Reset (rst=0, async): state IDLE, push=0, wdata=8'h00, busy=0, pending=0, byte index=0, BCD registers=0.
- Frame layout, index 0..7:
  - 0: 'U' (0x55) if mode=0, 'D' (0x44) if mode=1
  - 1: ':' (0x3A)
  - 2..5: thousands, hundreds, tens, ones as 0x30+digit
  - 6: 0x0D, 7: 0x0A (only when EOL_EN=1)
- Snapshot: count and mode are latched on the accepting edge. A count above MAX_CNT is clamped to MAX_CNT. Later input changes do not affect a frame in progress.
- FSM:
  - IDLE: on report_req=1 or pending=1, latch the snapshot, clear pending, pulse start to the converter, go to CONV. busy=1 from that edge.
  - CONV: wait for converter done (exactly 14 cycles after start), then go to SEND with index=0.
  - SEND: push = !fifo_full (combinational from the state register and fifo_full). wdata = frame[index], driven from a registered mux.
    - On each edge with push=1: index increments.
    - On the edge that pushes the last byte: go to IDLE, busy=0.
    - While fifo_full=1: index and wdata hold; no byte is lost or duplicated.
- Latency: with request at edge E0 and FIFO not full, push is first high during the cycle after E15. Consecutive bytes are pushed on consecutive edges, so the 8-byte frame completes at E23.
- Request while busy: sets pending (one deep). Further requests while pending=1 are dropped. The pending frame starts from IDLE on the cycle after busy falls, with the snapshot taken then.
- report_req coinciding with the last push edge: recorded as pending.
- Reset mid-frame: the frame aborts immediately and no further push occurs. Partial bytes already in the FIFO are not recalled.
- Arithmetic: double-dabble on the 14-bit value, 16-bit BCD result (four nibbles). Add-3 to any nibble >=5 before each shift.

Decomposition:
- Shared package counter_pkg:
  - report_state_t enum {IDLE, CONV, SEND}
  - ASCII constants CH_U, CH_D, CH_COLON, CH_ZERO, CH_CR, CH_LF
  - FRAME_LEN_EOL=8, FRAME_LEN_NOEOL=6
- One sub-module, bin2bcd_seq:
  - Ports: clk, rst, start, bin[13:0], bcd[15:0], done.
  - Iterative double-dabble over 14 cycles, done as a one-cycle pulse.
  - Verified standalone for 0, 9, 10, 99, 100, 999, 1000, 9999.

Test Plan:
- count=123, mode=0, req, fifo_full=0 -> bytes 55 3A 30 31 32 33 0D 0A on consecutive edges. First push in the cycle after E15; busy falls after the 8th push.
- count=9999, mode=1 -> 44 3A 39 39 39 39 0D 0A. count=0 -> 55 3A 30 30 30 30 0D 0A.
- count=12000 (above MAX_CNT) -> digits 39 39 39 39 (clamped).
- fifo_full held high 5 cycles after byte 2 -> push=0 and wdata=0x30 held throughout. Frame resumes with no gap or duplicate, for exactly 8 pushes total.
- Three reqs during busy (count changed to 42 meanwhile) -> exactly one extra frame "U:0042\r\n" starting right after the first frame; total 16 pushes.
- rst=0 asserted between pushes 3 and 4 -> push=0 and busy=0 asynchronously. After release, no pushes until a new report_req.

Source files
------------

// File: rtl/counter_pkg.sv
// Shared types and constants for the counter report path: FSM states,
// ASCII frame characters and frame lengths.
package counter_pkg;

    typedef enum logic [1:0] {
        IDLE,
        CONV,
        SEND
    } report_state_t;

    localparam logic [7:0] CH_U     = 8'h55;
    localparam logic [7:0] CH_D     = 8'h44;
    localparam logic [7:0] CH_COLON = 8'h3A;
    localparam logic [7:0] CH_ZERO  = 8'h30;
    localparam logic [7:0] CH_CR    = 8'h0D;
    localparam logic [7:0] CH_LF    = 8'h0A;

    localparam int FRAME_LEN_EOL   = 8;
    localparam int FRAME_LEN_NOEOL = 6;

    localparam int BIN_W      = 14;
    localparam int BCD_W      = 16;
    localparam int CONV_STEPS = 14;

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble: loads the binary value on start, performs one
// add-3/shift step per cycle and pulses done with the final four BCD digits.
module bin2bcd_seq
    import counter_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [BIN_W-1:0] bin,
    output logic [BCD_W-1:0] bcd,
    output logic             done
);

    localparam int SR_W = BCD_W + BIN_W;

    logic [SR_W-1:0] sr_q;
    logic [3:0]      steps_q;

    function automatic logic [SR_W-1:0] dabble_step(input logic [SR_W-1:0] sr);
        logic [SR_W-1:0] t;
        t = sr;
        for (int n = 0; n < BCD_W / 4; n++) begin
            if (t[BIN_W + 4*n +: 4] >= 4'd5)
                t[BIN_W + 4*n +: 4] = t[BIN_W + 4*n +: 4] + 4'd3;
        end
        return {t[SR_W-2:0], 1'b0};
    endfunction

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sr_q    <= '0;
            steps_q <= '0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            if (start) begin
                sr_q    <= {{BCD_W{1'b0}}, bin};
                steps_q <= 4'(CONV_STEPS);
            end else if (steps_q != 4'd0) begin
                sr_q    <= dabble_step(sr_q);
                steps_q <= steps_q - 4'd1;
                done    <= (steps_q == 4'd1);
            end
        end
    end

    assign bcd = sr_q[SR_W-1 -: BCD_W];

endmodule

// File: rtl/counter_report_tx.sv
// Turns a counter snapshot into an ASCII report frame ("U:0123\r\n") and
// pushes it byte by byte into the UART TX FIFO under push/full handshake.
module counter_report_tx
    import counter_pkg::*;
#(
    parameter int CNT_W   = 14,
    parameter int MAX_CNT = 9999,
    parameter bit EOL_EN  = 1'b1
)(
    input  logic             clk,
    input  logic             rst,
    input  logic [CNT_W-1:0] count,
    input  logic             mode,
    input  logic             report_req,
    input  logic             fifo_full,
    output logic             push,
    output logic [7:0]       wdata,
    output logic             busy
);

    localparam int         FRAME_LEN = EOL_EN ? FRAME_LEN_EOL : FRAME_LEN_NOEOL;
    localparam logic [2:0] LAST_IDX  = 3'(FRAME_LEN - 1);

    report_state_t    state_q, state_d;
    logic             pending_q;
    logic             mode_q;
    logic [2:0]       idx_q;
    logic             accept;
    logic [BCD_W-1:0] bcd;
    logic             conv_done;

    function automatic logic [BIN_W-1:0] sat_count(input logic [CNT_W-1:0] v);
        if (v > CNT_W'(MAX_CNT))
            return BIN_W'(MAX_CNT);
        return BIN_W'(v);
    endfunction

    function automatic logic [7:0] frame_byte(input logic [2:0]       idx,
                                              input logic             m,
                                              input logic [BCD_W-1:0] digits);
        logic [7:0] b;
        case (idx)
            3'd0:    b = m ? CH_D : CH_U;
            3'd1:    b = CH_COLON;
            3'd2:    b = CH_ZERO + {4'd0, digits[15:12]};
            3'd3:    b = CH_ZERO + {4'd0, digits[11:8]};
            3'd4:    b = CH_ZERO + {4'd0, digits[7:4]};
            3'd5:    b = CH_ZERO + {4'd0, digits[3:0]};
            3'd6:    b = CH_CR;
            default: b = CH_LF;
        endcase
        return b;
    endfunction

    // The converter's shift register holds the clamped count snapshot.
    bin2bcd_seq u_bin2bcd (
        .clk   (clk),
        .rst   (rst),
        .start (accept),
        .bin   (sat_count(count)),
        .bcd   (bcd),
        .done  (conv_done)
    );

    always_comb begin
        state_d = state_q;
        accept  = (state_q == IDLE) && (report_req || pending_q);
        push    = (state_q == SEND) && !fifo_full;
        busy    = (state_q != IDLE);
        case (state_q)
            IDLE:    if (accept) state_d = CONV;
            CONV:    if (conv_done) state_d = SEND;
            SEND:    if (push && idx_q == LAST_IDX) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            pending_q <= 1'b0;
            mode_q    <= 1'b0;
            idx_q     <= '0;
            wdata     <= 8'h00;
        end else begin
            state_q <= state_d;
            // A request that is not accepted this edge (busy) is held one deep.
            if (accept)
                pending_q <= 1'b0;
            else if (report_req)
                pending_q <= 1'b1;
            if (accept)
                mode_q <= mode;
            if (state_q == CONV && conv_done) begin
                idx_q <= '0;
                wdata <= frame_byte(3'd0, mode_q, bcd);
            end else if (push && idx_q != LAST_IDX) begin
                idx_q <= idx_q + 3'd1;
                wdata <= frame_byte(idx_q + 3'd1, mode_q, bcd);
            end
        end
    end

endmodule

// File: tb/tb_counter_report_tx.sv
// Scoreboard bench for counter_report_tx: expected frames are queued at
// request time and every pushed byte is popped and compared at negedge.
module tb_counter_report_tx;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [13:0] count = '0;
    logic        mode = 1'b0;
    logic        report_req = 1'b0;
    logic        fifo_full = 1'b0;
    logic        push;
    logic [7:0]  wdata;
    logic        busy;

    int          checks = 0;
    int          errors = 0;
    logic [7:0]  exp_q[$];
    logic [7:0]  mon_exp;

    counter_report_tx #(
        .CNT_W   (14),
        .MAX_CNT (9999),
        .EOL_EN  (1'b1)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .count      (count),
        .mode       (mode),
        .report_req (report_req),
        .fifo_full  (fifo_full),
        .push       (push),
        .wdata      (wdata),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (push) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL push_unexpected: got push with wdata=%02h, required no push", wdata);
            end else begin
                mon_exp = exp_q.pop_front();
                if (wdata !== mon_exp) begin
                    errors++;
                    $display("FAIL frame_byte: wdata=%02h, required %02h", wdata, mon_exp);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required normal completion");
        $fatal(1, "watchdog");
    end

    function automatic void enqueue(input int cnt, input logic m);
        int v;
        v = (cnt > 9999) ? 9999 : cnt;
        exp_q.push_back(m ? 8'h44 : 8'h55);
        exp_q.push_back(8'h3A);
        exp_q.push_back(8'(48 + v / 1000));
        exp_q.push_back(8'(48 + (v / 100) % 10));
        exp_q.push_back(8'(48 + (v / 10) % 10));
        exp_q.push_back(8'(48 + v % 10));
        exp_q.push_back(8'h0D);
        exp_q.push_back(8'h0A);
    endfunction

    // Returns #1 after the accepting edge E0, with report_req already low.
    task automatic send_req(input int cnt, input logic m, input logic expect_frame);
        @(posedge clk); #1;
        count      = 14'(cnt);
        mode       = m;
        report_req = 1'b1;
        if (expect_frame) enqueue(cnt, m);
        @(posedge clk); #1;
        report_req = 1'b0;
    endtask

    // Negedge n is the one following edge E_n of the request.
    task automatic wait_idle(input int budget, output int first, output int fall, output int pushes);
        first  = -1;
        fall   = -1;
        pushes = 0;
        for (int n = 0; n < budget; n++) begin
            @(negedge clk);
            if (push) begin
                if (first < 0) first = n;
                pushes++;
            end
            if (!busy) begin
                fall = n;
                break;
            end
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        checks++;
        if (push !== 1'b0 || busy !== 1'b0 || wdata !== 8'h00) begin
            errors++;
            $display("FAIL reset_state: push=%b busy=%b wdata=%02h, required 0 0 00", push, busy, wdata);
        end
        @(posedge clk); #1;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (push !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL idle_after_reset: push=%b busy=%b, required 0 0", push, busy);
        end
    endtask

    task automatic test_basic();
        int first, fall, pushes;
        send_req(123, 1'b0, 1'b1);
        count = 14'd7777;
        mode  = 1'b1;
        wait_idle(60, first, fall, pushes);
        checks++;
        if (first != 15) begin
            errors++;
            $display("FAIL basic_latency: first push after edge %0d, required 15", first);
        end
        checks++;
        if (fall != 23) begin
            errors++;
            $display("FAIL basic_busy_fall: busy low after edge %0d, required 23", fall);
        end
        checks++;
        if (pushes != 8) begin
            errors++;
            $display("FAIL basic_push_count: %0d pushes, required 8", pushes);
        end
    endtask

    task automatic test_extremes();
        int first, fall, pushes;
        send_req(9999, 1'b1, 1'b1);
        wait_idle(60, first, fall, pushes);
        checks++;
        if (pushes != 8 || fall != 23) begin
            errors++;
            $display("FAIL max_frame: pushes=%0d fall=%0d, required 8 23", pushes, fall);
        end
        send_req(0, 1'b0, 1'b1);
        wait_idle(60, first, fall, pushes);
        checks++;
        if (pushes != 8 || first != 15) begin
            errors++;
            $display("FAIL zero_frame: pushes=%0d first=%0d, required 8 15", pushes, first);
        end
    endtask

    task automatic test_clamp();
        int first, fall, pushes;
        send_req(12000, 1'b0, 1'b1);
        wait_idle(60, first, fall, pushes);
        checks++;
        if (pushes != 8 || fall != 23) begin
            errors++;
            $display("FAIL clamp_frame: pushes=%0d fall=%0d, required 8 23", pushes, fall);
        end
    endtask

    task automatic test_backpressure();
        int pushes;
        int fall;
        pushes = 0;
        fall   = -1;
        send_req(123, 1'b0, 1'b1);
        for (int i = 0; i < 60 && pushes < 2; i++) begin
            @(negedge clk);
            if (push) pushes++;
        end
        @(posedge clk); #1;
        fifo_full = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            checks++;
            if (push !== 1'b0 || wdata !== 8'h30) begin
                errors++;
                $display("FAIL full_hold: push=%b wdata=%02h, required 0 30", push, wdata);
            end
        end
        @(posedge clk); #1;
        fifo_full = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (push) pushes++;
            if (!busy) begin
                fall = i;
                break;
            end
        end
        checks++;
        if (pushes != 8 || fall < 0) begin
            errors++;
            $display("FAIL full_push_count: pushes=%0d fall=%0d, required 8 pushes and busy low", pushes, fall);
        end
    endtask

    task automatic test_back_to_back();
        int first, fall, pushes;
        int first2, fall2, pushes2;
        int quiet;
        send_req(123, 1'b0, 1'b1);
        fork
            wait_idle(60, first, fall, pushes);
            begin
                repeat (3) @(posedge clk);
                #1;
                count      = 14'd42;
                report_req = 1'b1;
                enqueue(42, 1'b0);
                @(posedge clk); #1;
                report_req = 1'b0;
                repeat (4) @(posedge clk);
                #1;
                report_req = 1'b1;
                @(posedge clk); #1;
                report_req = 1'b0;
                repeat (6) @(posedge clk);
                #1;
                report_req = 1'b1;
                @(posedge clk); #1;
                report_req = 1'b0;
            end
        join
        checks++;
        if (pushes != 8 || fall != 23) begin
            errors++;
            $display("FAIL b2b_first_frame: pushes=%0d fall=%0d, required 8 23", pushes, fall);
        end
        wait_idle(60, first2, fall2, pushes2);
        checks++;
        if (first2 != 15 || fall2 != 23 || pushes2 != 8) begin
            errors++;
            $display("FAIL b2b_pending_frame: first=%0d fall=%0d pushes=%0d, required 15 23 8",
                     first2, fall2, pushes2);
        end
        quiet = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (push || busy) quiet++;
        end
        checks++;
        if (quiet != 0) begin
            errors++;
            $display("FAIL b2b_no_third_frame: %0d active cycles, required 0", quiet);
        end
    endtask

    task automatic test_reset_mid_frame();
        int pushes;
        int active;
        pushes = 0;
        send_req(123, 1'b0, 1'b1);
        for (int i = 0; i < 60 && pushes < 3; i++) begin
            @(negedge clk);
            if (push) pushes++;
        end
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        checks++;
        if (push !== 1'b0 || busy !== 1'b0 || wdata !== 8'h00) begin
            errors++;
            $display("FAIL reset_abort: push=%b busy=%b wdata=%02h, required 0 0 00", push, busy, wdata);
        end
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        active = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (push || busy) active++;
        end
        checks++;
        if (active != 0) begin
            errors++;
            $display("FAIL reset_quiet: %0d active cycles after release, required 0", active);
        end
    endtask

    task automatic test_recovery();
        int first, fall, pushes;
        send_req(5678, 1'b1, 1'b1);
        wait_idle(60, first, fall, pushes);
        checks++;
        if (first != 15 || fall != 23 || pushes != 8) begin
            errors++;
            $display("FAIL recovery_frame: first=%0d fall=%0d pushes=%0d, required 15 23 8",
                     first, fall, pushes);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_extremes();
        test_clamp();
        test_backpressure();
        test_back_to_back();
        test_reset_mid_frame();
        test_recovery();
        repeat (3) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d bytes never pushed, required 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
